// File: rtl/timer_dev_pkg.sv
// Shared definitions for the countdown timer: register offsets, FSM states,
// CTRL bit positions, mode codes and a small decode helper.
package timer_dev_pkg;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    localparam int EN      = 0;
    localparam int MODE_LO = 1;
    localparam int MODE_HI = 2;
    localparam int IM      = 3;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_CNT  = 2'd2,
        T_INT  = 2'd3
    } tstate_e;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01
    } mode_e;

    // Only the exact periodic code reloads; both 1x codes behave as one-shot.
    function automatic logic is_periodic(input logic [3:0] ctrl);
        return (mode_e'(ctrl[MODE_HI:MODE_LO]) == MODE_PERIODIC);
    endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Device-bus connection between the CPU bridge (master) and the timer (slave).
interface timer_dev_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (output Addr, output WE, output DIn, input DOut, input IRQ);
    modport slave  (input Addr, input WE, input DIn, output DOut, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Programmable countdown timer with CTRL/PRESET/COUNT registers, one-shot and
// periodic modes, and a maskable interrupt request.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);

    tstate_e     state_r;
    tstate_e     state_s;
    logic [3:0]  ctrl_r;
    logic [3:0]  ctrl_s;
    logic [31:0] preset_r;
    logic [31:0] preset_s;
    logic [31:0] count_r;
    logic [31:0] count_s;
    logic        irq_flag_r;
    logic        irq_flag_s;

    // Next-state and next-register computation; CPU writes are applied last so they win.
    always_comb begin
        state_s    = state_r;
        ctrl_s     = ctrl_r;
        preset_s   = preset_r;
        count_s    = count_r;
        irq_flag_s = irq_flag_r;

        case (state_r)
            T_IDLE: begin
                if (ctrl_r[EN]) begin
                    state_s = T_LOAD;
                end else begin
                    state_s = T_IDLE;
                end
            end
            T_LOAD: begin
                count_s = preset_r;
                state_s = T_CNT;
            end
            T_CNT: begin
                if (!ctrl_r[EN]) begin
                    state_s = T_IDLE;
                end else if (count_r != 32'd0) begin
                    count_s = count_r - 32'd1;
                end else begin
                    state_s    = T_INT;
                    irq_flag_s = 1'b1;
                end
            end
            T_INT: begin
                if (is_periodic(ctrl_r)) begin
                    irq_flag_s = 1'b0;
                    state_s    = T_LOAD;
                end else begin
                    ctrl_s[EN] = 1'b0;
                    state_s    = T_IDLE;
                end
            end
            default: begin
                state_s = T_IDLE;
            end
        endcase

        // COUNT and the reserved offset are read-only from the bus.
        case ({bus.WE, bus.Addr})
            {1'b1, TIMER_CTRL}: begin
                ctrl_s     = bus.DIn[3:0];
                irq_flag_s = 1'b0;
            end
            {1'b1, TIMER_PRESET}: begin
                preset_s = bus.DIn;
            end
            default: begin
                preset_s = preset_s;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= T_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Programmer-visible registers and the pending-interrupt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r     <= 4'd0;
            preset_r   <= PRESET_RST;
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
        end else begin
            ctrl_r     <= ctrl_s;
            preset_r   <= preset_s;
            count_r    <= count_s;
            irq_flag_r <= irq_flag_s;
        end
    end

    // Zero-latency read mux; the reserved offset reads as zero.
    always_comb begin
        case (bus.Addr)
            TIMER_CTRL:   bus.DOut = {28'd0, ctrl_r};
            TIMER_PRESET: bus.DOut = preset_r;
            TIMER_COUNT:  bus.DOut = count_r;
            default:      bus.DOut = 32'd0;
        endcase
    end

    assign bus.IRQ = irq_flag_r & ctrl_r[IM];

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues expected DOut/IRQ per probed
// cycle, a negedge monitor pops and compares.
module tb_timer_dev;

    localparam logic [31:0] PRST = 32'h0000_0005;

    typedef struct {
        string       nm;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    logic clk;
    logic reset;
    logic chk_valid;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] os_cnt  [7]  = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    bit          os_irq  [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] per_cnt [5]  = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0};
    bit          per_irq [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] msk_ctl [8]  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    bit          p0_irq  [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] dis_cnt [5]  = '{32'd0, 32'd0, 32'd10, 32'd9, 32'd8};
    logic [31:0] col_cnt [6]  = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};

    timer_dev_if bus ();

    timer_dev #(.PRESET_RST(PRST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle, driven just after the rising edge; optionally queues an expectation.
    task automatic drive(input logic rst, input logic we, input logic [1:0] addr,
                         input logic [31:0] din, input bit chk,
                         input logic [31:0] edout, input logic eirq, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        bus.WE    = we;
        bus.Addr  = addr;
        bus.DIn   = din;
        chk_valid = chk;
        if (chk) begin
            e.nm   = nm;
            e.dout = edout;
            e.irq  = eirq;
            sb_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] din);
        drive(1'b0, 1'b1, addr, din, 1'b0, 32'd0, 1'b0, "");
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] edout,
                      input logic eirq, input string nm);
        drive(1'b0, 1'b0, addr, 32'd0, 1'b1, edout, eirq, nm);
    endtask

    task automatic do_reset(input logic we, input logic [1:0] addr, input logic [31:0] din);
        drive(1'b1, we, addr, din, 1'b0, 32'd0, 1'b0, "");
    endtask

    // Monitor: compare the DUT's combinational outputs mid-cycle against the queue head.
    always @(negedge clk) begin
        if (chk_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: probe with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.DOut !== mon_e.dout || bus.IRQ !== mon_e.irq) begin
                    failures++;
                    $display("FAIL %s: got dout=%h irq=%b, expected dout=%h irq=%b @%0t",
                             mon_e.nm, bus.DOut, bus.IRQ, mon_e.dout, mon_e.irq, $time);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        chk_valid = 1'b0;
        bus.WE    = 1'b0;
        bus.Addr  = 2'd0;
        bus.DIn   = 32'd0;

        // Reset state
        do_reset(1'b0, 2'd0, 32'd0);
        rd(2'd0, 32'd0, 1'b0, "rst_ctrl");
        rd(2'd1, PRST,  1'b0, "rst_preset");
        rd(2'd2, 32'd0, 1'b0, "rst_count");
        rd(2'd3, 32'd0, 1'b0, "rst_rsvd");

        // One-shot, PRESET=3, IM=1
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd9);
        for (int k = 0; k < 7; k++) rd(2'd2, os_cnt[k], os_irq[k], "oneshot_count");
        rd(2'd0, 32'd8, 1'b1, "oneshot_en_clr");
        repeat (20) rd(2'd0, 32'd8, 1'b1, "oneshot_irq_hold");
        wr(2'd0, 32'd0);
        rd(2'd0, 32'd0, 1'b0, "oneshot_irq_drop");

        // Periodic, PRESET=2: pulse every 5 cycles
        do_reset(1'b0, 2'd0, 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd11);
        rd(2'd2, 32'd0, 1'b0, "per_idle");
        for (int k = 1; k < 22; k++) rd(2'd2, per_cnt[(k - 1) % 5], per_irq[(k - 1) % 5], "per_count");

        // Masked one-shot, PRESET=1
        do_reset(1'b0, 2'd0, 32'd0);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd1);
        for (int k = 0; k < 8; k++) rd(2'd0, msk_ctl[k], 1'b0, "mask_ctrl");

        // PRESET=0 boundary, reserved offset reads zero
        do_reset(1'b0, 2'd0, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd9);
        for (int k = 0; k < 5; k++) rd(2'd3, 32'd0, p0_irq[k], "preset0_irq");

        // Disable mid-count, then re-enable reloads
        do_reset(1'b0, 2'd0, 32'd0);
        wr(2'd1, 32'd10);
        wr(2'd0, 32'd1);
        for (int k = 0; k < 5; k++) rd(2'd2, dis_cnt[k], 1'b0, "dis_count");
        wr(2'd0, 32'd0);
        repeat (5) rd(2'd2, 32'd6, 1'b0, "dis_frozen");
        rd(2'd0, 32'd0, 1'b0, "dis_ctrl");
        wr(2'd0, 32'd1);
        rd(2'd2, 32'd6,  1'b0, "dis_idle");
        rd(2'd2, 32'd6,  1'b0, "dis_load");
        rd(2'd2, 32'd10, 1'b0, "dis_reload");
        rd(2'd2, 32'd9,  1'b0, "dis_recount");

        // Collision: CTRL write on the CNT->INT edge clears the flag
        do_reset(1'b0, 2'd0, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd9);
        for (int k = 0; k < 5; k++) rd(2'd2, col_cnt[k], 1'b0, "colA_count");
        wr(2'd0, 32'd9);
        rd(2'd0, 32'd9, 1'b0, "colA_int_noirq");
        repeat (3) rd(2'd0, 32'd8, 1'b0, "colA_idle");

        // Collision: CTRL write on the INT edge keeps En and restarts
        do_reset(1'b0, 2'd0, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd9);
        for (int k = 0; k < 6; k++) rd(2'd2, col_cnt[k], 1'b0, "colB_count");
        drive(1'b0, 1'b1, 2'd0, 32'd9, 1'b1, 32'd9, 1'b1, "colB_int");
        rd(2'd0, 32'd9, 1'b0, "colB_en_kept");
        rd(2'd2, 32'd0, 1'b0, "colB_load");
        drive(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b1, 32'd3, 1'b0, "colB_cnt3");
        rd(2'd2, 32'd2, 1'b0, "colB_addr2_ignored");
        rd(2'd2, 32'd1, 1'b0, "colB_cnt1");
        rd(2'd2, 32'd0, 1'b0, "colB_cnt0");
        rd(2'd2, 32'd0, 1'b1, "colB_refire");

        // Reset beats a simultaneous CTRL write
        do_reset(1'b1, 2'd0, 32'd9);
        rd(2'd0, 32'd0, 1'b0, "rstwe_ctrl");
        rd(2'd1, PRST,  1'b0, "rstwe_preset");
        rd(2'd2, 32'd0, 1'b0, "rstwe_count");
        rd(2'd2, 32'd0, 1'b0, "rstwe_stays_idle");

        drive(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
